// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared state encodings, segment bit order and hex decoder
//
// Purpose: definitions shared by seg_scan_ctrl and hc595_shifter.
// Ports: none (package).
package seg_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_HOLD  = 3'd4
  } scan_state_e;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_LATCH = 2'd2
  } shift_state_e;

  // Segment byte layout is {dp,g,f,e,d,c,b,a}; segment a sits in bit 0.
  localparam int SEG_DP_BIT = 7;

  // Active-high segment pattern for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hc595_shifter.sv
// rtl/seg_scan_ctrl_hc595_shifter.sv - serialises one byte into a 74HC595 and latches it
//
// Purpose: on start, shifts data_byte MSB first (hc595_clk low then high for
//   CLK_DIV cycles per bit), then pulses hc595_cs high for CLK_DIV cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, data_byte      begin a transfer of data_byte (accepted only when idle)
//   busy                  transfer in progress
//   done                  high in the last hc595_cs-high cycle
//   hc595_data/clk/cs     pins to the shift register
module hc595_shifter
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_byte,
  output logic       busy,
  output logic       done,
  output logic       hc595_data,
  output logic       hc595_clk,
  output logic       hc595_cs
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  shift_state_e     state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             high_q, high_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sr_q, sr_d;
  logic             sclk_q, sclk_d;
  logic             cs_q, cs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SH_IDLE;
      div_q   <= '0;
      high_q  <= 1'b0;
      bit_q   <= 3'd0;
      sr_q    <= 8'h00;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      high_q  <= high_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    high_d  = high_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    done    = 1'b0;
    case (state_q)
      SH_IDLE: begin
        if (start) begin
          state_d = SH_SHIFT;
          sr_d    = data_byte;
          div_d   = '0;
          high_d  = 1'b0;
          bit_d   = 3'd0;
          sclk_d  = 1'b0;
        end
      end
      SH_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!high_q) begin
            sclk_d = 1'b1;
            high_d = 1'b1;
          end else begin
            // Falling edge: the next bit moves onto hc595_data while the clock is low.
            // After the 8th bit the register is all zeros, so the data pin idles low.
            sclk_d = 1'b0;
            high_d = 1'b0;
            sr_d   = {sr_q[6:0], 1'b0};
            if (bit_q == 3'd7) begin
              state_d = SH_LATCH;
              cs_d    = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SH_LATCH: begin
        if (div_q == DIV_LAST) begin
          done    = 1'b1;
          cs_d    = 1'b0;
          div_d   = '0;
          state_d = SH_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = SH_IDLE;
    endcase
  end

  assign busy       = (state_q != SH_IDLE);
  assign hc595_data = sr_q[7];
  assign hc595_clk  = sclk_q;
  assign hc595_cs   = cs_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit seven-segment scan controller driving a 74HC595
//
// Purpose: snapshots four hex digits per frame, decodes each to a segment byte,
//   shifts/latches it via hc595_shifter, then selects that digit for HOLD_CYCLES.
// Ports:
//   osc_clk, sys_rst_n     clock, synchronous active-low reset
//   disp_data[15:0]        digits, [3:0] -> seg_c1 ... [15:12] -> seg_c4
//   disp_dp[3:0]           decimal points, 1 = lit
//   disp_blank[3:0]        1 = digit dark (overrides data and dp)
//   disp_en                scanning enable
//   seg_c1..seg_c4         digit selects
//   hc595_data/clk/cs      shift register pins
//   frame_done             one-cycle pulse after the seg_c4 hold
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 50000,
  parameter int DIG_ACT_LOW = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic        osc_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] disp_data,
  input  logic [3:0]  disp_dp,
  input  logic [3:0]  disp_blank,
  input  logic        disp_en,
  output logic        seg_c1,
  output logic        seg_c2,
  output logic        seg_c3,
  output logic        seg_c4,
  output logic        hc595_data,
  output logic        hc595_clk,
  output logic        hc595_cs,
  output logic        frame_done
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  scan_state_e       state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       snap_data_q, snap_data_d;
  logic [3:0]        snap_dp_q, snap_dp_d;
  logic [3:0]        snap_blank_q, snap_blank_d;
  logic              frame_done_q, frame_done_d;

  logic              take_snap;
  logic              sh_start;
  logic              sh_busy;
  logic              sh_done;
  logic [7:0]        seg_byte;
  logic [3:0]        sel;

  always_ff @(posedge osc_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      hold_q       <= '0;
      snap_data_q  <= 16'h0000;
      snap_dp_q    <= 4'h0;
      snap_blank_q <= 4'h0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    frame_done_d = 1'b0;
    take_snap    = 1'b0;
    sh_start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (disp_en) begin
          state_d   = ST_LOAD;
          take_snap = 1'b1;
        end
      end
      ST_LOAD: begin
        sh_start = !sh_busy;
        state_d  = ST_SHIFT;
      end
      // The shifter owns pin timing; these states only track its phase.
      ST_SHIFT: begin
        if (sh_done) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end else if (hc595_cs) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (sh_done) begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d       = '0;
          frame_done_d = (idx_q == 2'd3);
          if (disp_en) begin
            state_d   = ST_LOAD;
            idx_d     = idx_q + 2'd1;
            // Snapshot only at a frame boundary so a frame never mixes old and new digits.
            take_snap = (idx_q == 2'd3);
          end else begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    snap_data_d  = take_snap ? disp_data  : snap_data_q;
    snap_dp_d    = take_snap ? disp_dp    : snap_dp_q;
    snap_blank_d = take_snap ? disp_blank : snap_blank_q;
  end

  always_comb begin
    logic [7:0] raw;
    raw = 8'h00;
    if (!snap_blank_q[idx_q]) begin
      raw[6:0]        = hex_to_seg(snap_data_q[{idx_q, 2'b00} +: 4]);
      raw[SEG_DP_BIT] = snap_dp_q[idx_q];
    end
    seg_byte = (SEG_ACT_LOW != 0) ? ~raw : raw;
  end

  hc595_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk       (osc_clk),
    .rst_n     (sys_rst_n),
    .start     (sh_start),
    .data_byte (seg_byte),
    .busy      (sh_busy),
    .done      (sh_done),
    .hc595_data(hc595_data),
    .hc595_clk (hc595_clk),
    .hc595_cs  (hc595_cs)
  );

  // Only HOLD drives a select, so LOAD/SHIFT/LATCH keep every digit dark.
  assign sel = (state_q == ST_HOLD) ? (4'b0001 << idx_q) : 4'b0000;

  assign seg_c1     = (DIG_ACT_LOW != 0) ? ~sel[0] : sel[0];
  assign seg_c2     = (DIG_ACT_LOW != 0) ? ~sel[1] : sel[1];
  assign seg_c3     = (DIG_ACT_LOW != 0) ? ~sel[2] : sel[2];
  assign seg_c4     = (DIG_ACT_LOW != 0) ? ~sel[3] : sel[3];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int CLK_DIV      = 2;
  localparam int HOLD         = 20;
  localparam int DIGIT_PERIOD = 1 + 17 * CLK_DIV + HOLD;
  localparam int FRAME_PERIOD = 4 * DIGIT_PERIOD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] disp_data = 16'h0000;
  logic [3:0]  disp_dp = 4'h0;
  logic [3:0]  disp_blank = 4'h0;
  logic        disp_en = 1'b0;
  logic        seg_c1, seg_c2, seg_c3, seg_c4;
  logic        hc595_data, hc595_clk, hc595_cs, frame_done;

  seg_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD), .DIG_ACT_LOW(1), .SEG_ACT_LOW(1)
  ) dut (
    .osc_clk(clk), .sys_rst_n(rst_n), .disp_data(disp_data), .disp_dp(disp_dp),
    .disp_blank(disp_blank), .disp_en(disp_en),
    .seg_c1(seg_c1), .seg_c2(seg_c2), .seg_c3(seg_c3), .seg_c4(seg_c4),
    .hc595_data(hc595_data), .hc595_clk(hc595_clk), .hc595_cs(hc595_cs),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Pin-level observations: one record per completed digit hold.
  logic [7:0] rec_byte [$];
  int         rec_bits [$];
  logic [3:0] rec_sel  [$];
  int         rec_len  [$];
  int         fd_cyc   [$];
  int         cyc = 0, clk_edges = 0, cs_pulses = 0, overlap = 0, ghost = 0;
  logic [3:0] sel_now = 4'h0;

  // Byte the 74HC595 should hold for digit k (active-low segments).
  function automatic logic [7:0] exp_byte(input logic [15:0] d, input logic [3:0] dp,
                                          input logic [3:0] bl, input int k);
    logic [3:0] nib;
    nib = d[k*4 +: 4];
    if (bl[k]) return 8'hFF;
    return ~{dp[k], seg_tab[nib]};
  endfunction

  initial begin : monitor
    logic       prev_clk, prev_cs;
    logic [7:0] sr, last_byte;
    logic [3:0] cur_sel, sel_prev;
    int         bits, last_bits, hold_len;
    prev_clk = 0; prev_cs = 0; sr = 0; last_byte = 0; cur_sel = 0; sel_prev = 0;
    bits = 0; last_bits = 0; hold_len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      sel_now = ~{seg_c4, seg_c3, seg_c2, seg_c1};
      if (!rst_n) begin
        sr = 0; bits = 0; prev_clk = 0; prev_cs = 0; sel_prev = 0; hold_len = 0; cur_sel = 0;
      end else begin
        if (hc595_clk && !prev_clk) begin
          sr = {sr[6:0], hc595_data};
          bits++;
          clk_edges++;
        end
        if (hc595_cs && !prev_cs) begin
          last_byte = sr; last_bits = bits; bits = 0; cs_pulses++;
        end
        if ($countones(sel_now) > 1) overlap++;
        if (sel_now != 0 && (hc595_cs || hc595_clk)) ghost++;
        if (sel_now != 0) begin
          if (sel_prev == 0) begin cur_sel = sel_now; hold_len = 0; end
          hold_len++;
        end else if (sel_prev != 0) begin
          rec_byte.push_back(last_byte); rec_bits.push_back(last_bits);
          rec_sel.push_back(cur_sel);    rec_len.push_back(hold_len);
        end
        if (frame_done) fd_cyc.push_back(cyc);
        prev_clk = hc595_clk; prev_cs = hc595_cs; sel_prev = sel_now;
      end
    end
  end

  task automatic restart(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    @(negedge clk);
    rst_n = 0; disp_data = d; disp_dp = dp; disp_blank = bl; disp_en = 1;
    repeat (2) @(negedge clk);
    rec_byte.delete(); rec_bits.delete(); rec_sel.delete(); rec_len.delete(); fd_cyc.delete();
    overlap = 0; ghost = 0;
    rst_n = 1;
  endtask

  task automatic wait_recs(input int n);
    int t = 0;
    while (rec_byte.size() < n && t < 4 * FRAME_PERIOD) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    int t, cs0;
    rst_n = 0; disp_en = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({seg_c4, seg_c3, seg_c2, seg_c1} !== 4'hF) begin n_bad++; $display("FAIL reset_sel: got %b, required 1111", {seg_c4, seg_c3, seg_c2, seg_c1}); end
    n_cmp++; if ({hc595_data, hc595_clk, hc595_cs} !== 3'b000) begin n_bad++; $display("FAIL reset_hc595: got %b, required 000", {hc595_data, hc595_clk, hc595_cs}); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
    rst_n = 1; disp_data = 16'h1234; disp_dp = 0; disp_blank = 0; disp_en = 1;
    t = 0;
    while (hc595_clk !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if (hc595_clk !== 1'b1) begin n_bad++; $display("FAIL reset_reach_shift: hc595_clk %b, required 1", hc595_clk); end
    cs0 = cs_pulses;
    rst_n = 0;
    @(negedge clk);
    n_cmp++; if ({seg_c4, seg_c3, seg_c2, seg_c1} !== 4'hF) begin n_bad++; $display("FAIL midreset_sel: got %b, required 1111", {seg_c4, seg_c3, seg_c2, seg_c1}); end
    n_cmp++; if ({hc595_data, hc595_clk, hc595_cs} !== 3'b000) begin n_bad++; $display("FAIL midreset_hc595: got %b, required 000", {hc595_data, hc595_clk, hc595_cs}); end
    repeat (2) @(negedge clk);
    n_cmp++; if (cs_pulses != cs0) begin n_bad++; $display("FAIL midreset_cs: pulses %0d, required %0d", cs_pulses, cs0); end
    rec_byte.delete(); rec_bits.delete(); rec_sel.delete(); rec_len.delete(); fd_cyc.delete();
    rst_n = 1;
    wait_recs(1);
    n_cmp++; if (rec_byte.size() < 1) begin n_bad++; $display("FAIL midreset_timeout: records %0d, required 1", rec_byte.size()); end
    else begin
      n_cmp++; if (rec_bits[0] != 8) begin n_bad++; $display("FAIL midreset_bits: got %0d, required 8", rec_bits[0]); end
      n_cmp++; if (rec_byte[0] !== exp_byte(16'h1234, 0, 0, 0)) begin n_bad++; $display("FAIL midreset_byte: got %h, required %h", rec_byte[0], exp_byte(16'h1234, 0, 0, 0)); end
      n_cmp++; if (cs_pulses != cs0 + 1) begin n_bad++; $display("FAIL midreset_cs_after: pulses %0d, required %0d", cs_pulses, cs0 + 1); end
    end
  endtask

  task automatic test_decode();
    restart(16'h1234, 4'h0, 4'h0);
    wait_recs(1);
    n_cmp++; if (rec_byte.size() < 1) begin n_bad++; $display("FAIL decode_timeout: records %0d, required 1", rec_byte.size()); end
    else begin
      n_cmp++; if (rec_byte[0] !== 8'h99) begin n_bad++; $display("FAIL decode_byte: got %h, required 99", rec_byte[0]); end
      n_cmp++; if (rec_sel[0] !== 4'b0001) begin n_bad++; $display("FAIL decode_sel: got %b, required 0001", rec_sel[0]); end
      n_cmp++; if (rec_len[0] != HOLD) begin n_bad++; $display("FAIL decode_hold: got %0d, required %0d", rec_len[0], HOLD); end
      n_cmp++; if (rec_bits[0] != 8) begin n_bad++; $display("FAIL decode_bits: got %0d, required 8", rec_bits[0]); end
    end
  endtask

  task automatic test_frame();
    logic [15:0] d;
    logic [3:0]  dp, bl;
    restart(16'h1234, 4'h0, 4'h0);
    wait_recs(8);
    repeat (2) @(negedge clk);
    n_cmp++; if (rec_byte.size() < 8) begin n_bad++; $display("FAIL frame_timeout: records %0d, required 8", rec_byte.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (rec_byte[i] !== exp_byte(16'h1234, 0, 0, i % 4)) begin n_bad++; $display("FAIL frame_byte[%0d]: got %h, required %h", i, rec_byte[i], exp_byte(16'h1234, 0, 0, i % 4)); end
        n_cmp++; if (rec_sel[i] !== 4'(1 << (i % 4))) begin n_bad++; $display("FAIL frame_sel[%0d]: got %b, required %b", i, rec_sel[i], 4'(1 << (i % 4))); end
        n_cmp++; if (rec_len[i] != HOLD) begin n_bad++; $display("FAIL frame_hold[%0d]: got %0d, required %0d", i, rec_len[i], HOLD); end
      end
    end
    n_cmp++; if (fd_cyc.size() < 2) begin n_bad++; $display("FAIL frame_done_count: got %0d, required 2", fd_cyc.size()); end
    else begin
      n_cmp++; if (fd_cyc[1] - fd_cyc[0] != FRAME_PERIOD) begin n_bad++; $display("FAIL frame_period: got %0d, required %0d", fd_cyc[1] - fd_cyc[0], FRAME_PERIOD); end
    end
    n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL frame_overlap: got %0d, required 0", overlap); end
    n_cmp++; if (ghost != 0) begin n_bad++; $display("FAIL frame_ghost: got %0d, required 0", ghost); end
    for (int r = 0; r < 4; r++) begin
      d  = 16'($urandom);
      dp = 4'($urandom_range(0, 15));
      bl = 4'($urandom_range(0, 15));
      restart(d, dp, bl);
      wait_recs(4);
      n_cmp++; if (rec_byte.size() < 4) begin n_bad++; $display("FAIL rand_timeout[%0d]: records %0d, required 4", r, rec_byte.size()); end
      else begin
        for (int k = 0; k < 4; k++) begin
          n_cmp++; if (rec_byte[k] !== exp_byte(d, dp, bl, k)) begin n_bad++; $display("FAIL rand_byte[%0d][%0d]: got %h, required %h (d=%h dp=%b bl=%b)", r, k, rec_byte[k], exp_byte(d, dp, bl, k), d, dp, bl); end
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    restart(16'h0000, 4'b0001, 4'b0010);
    wait_recs(2);
    n_cmp++; if (rec_byte.size() < 2) begin n_bad++; $display("FAIL blank_timeout: records %0d, required 2", rec_byte.size()); end
    else begin
      n_cmp++; if (rec_byte[0] !== 8'h40) begin n_bad++; $display("FAIL dp_byte: got %h, required 40", rec_byte[0]); end
      n_cmp++; if (rec_byte[1] !== 8'hFF) begin n_bad++; $display("FAIL blank_byte: got %h, required FF", rec_byte[1]); end
    end
  endtask

  task automatic test_tearing();
    int t = 0;
    restart(16'h1234, 4'h0, 4'h0);
    while (!(rec_byte.size() == 2 && sel_now == 4'b0100) && t < 2 * FRAME_PERIOD) begin @(negedge clk); t++; end
    n_cmp++; if (sel_now !== 4'b0100) begin n_bad++; $display("FAIL tear_reach_c3: sel %b, required 0100", sel_now); end
    disp_data = 16'hABCD; disp_blank = 4'b1000;
    wait_recs(8);
    n_cmp++; if (rec_byte.size() < 8) begin n_bad++; $display("FAIL tear_timeout: records %0d, required 8", rec_byte.size()); end
    else begin
      n_cmp++; if (rec_byte[3] !== exp_byte(16'h1234, 0, 0, 3)) begin n_bad++; $display("FAIL tear_old_c4: got %h, required %h", rec_byte[3], exp_byte(16'h1234, 0, 0, 3)); end
      n_cmp++; if (rec_byte[4] !== exp_byte(16'hABCD, 0, 4'b1000, 0)) begin n_bad++; $display("FAIL tear_new_c1: got %h, required %h", rec_byte[4], exp_byte(16'hABCD, 0, 4'b1000, 0)); end
      n_cmp++; if (rec_byte[7] !== 8'hFF) begin n_bad++; $display("FAIL tear_new_blank: got %h, required FF", rec_byte[7]); end
    end
  endtask

  task automatic test_enable();
    int t = 0;
    int e0, c0;
    restart(16'h1234, 4'h0, 4'h0);
    wait_recs(1);
    while (hc595_clk !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_cmp++; if (hc595_clk !== 1'b1) begin n_bad++; $display("FAIL en_reach_shift: hc595_clk %b, required 1", hc595_clk); end
    disp_en = 0;
    wait_recs(2);
    e0 = clk_edges; c0 = cs_pulses;
    repeat (80) @(negedge clk);
    n_cmp++; if (rec_byte.size() != 2) begin n_bad++; $display("FAIL en_records: got %0d, required 2", rec_byte.size()); end
    else begin
      n_cmp++; if (rec_sel[1] !== 4'b0010) begin n_bad++; $display("FAIL en_last_sel: got %b, required 0010", rec_sel[1]); end
      n_cmp++; if (rec_len[1] != HOLD) begin n_bad++; $display("FAIL en_last_hold: got %0d, required %0d", rec_len[1], HOLD); end
    end
    n_cmp++; if (clk_edges != e0) begin n_bad++; $display("FAIL en_idle_clk: edges %0d, required %0d", clk_edges, e0); end
    n_cmp++; if (cs_pulses != c0) begin n_bad++; $display("FAIL en_idle_cs: pulses %0d, required %0d", cs_pulses, c0); end
    n_cmp++; if (sel_now !== 4'b0000) begin n_bad++; $display("FAIL en_idle_sel: got %b, required 0000", sel_now); end
    disp_data = 16'h5678;
    disp_en = 1;
    wait_recs(3);
    n_cmp++; if (rec_byte.size() < 3) begin n_bad++; $display("FAIL en_restart_timeout: records %0d, required 3", rec_byte.size()); end
    else begin
      n_cmp++; if (rec_sel[2] !== 4'b0001) begin n_bad++; $display("FAIL en_restart_sel: got %b, required 0001", rec_sel[2]); end
      n_cmp++; if (rec_byte[2] !== exp_byte(16'h5678, 0, 0, 0)) begin n_bad++; $display("FAIL en_restart_byte: got %h, required %h", rec_byte[2], exp_byte(16'h5678, 0, 0, 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_frame();
    test_blank_dp();
    test_tearing();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
